regfile_dump: RTL and testbench

//  Debug reader on the far side of the register-file read ports.
//  On a dump request it walks register indices in order and reads each one through a

---
 rtl/regfile_dump.sv | 107 ++++++++++
 tb/tb_regfile_dump.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump.sv
// Debug reader that walks the register file through a dedicated read port and
// streams every register value out over a valid/ready beat interface.
module regfile_dump #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_REGS = 32,
   parameter int SKIP_X0  = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dump_req,
   output logic              dump_busy,
   output logic              core_stall,
   output logic              dump_done,
   output logic [ADDR_W-1:0] rf_rd_addr,
   input  logic [DATA_W-1:0] rf_rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic [1:0]        dbg_state
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_READ = 2'd1;
   localparam logic [1:0] S_SEND = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [ADDR_W-1:0] FIRST_IDX = (SKIP_X0 != 0) ? ADDR_W'(1) : '0;
   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

   // Beat handshake: a beat transfers on a rising edge where out_valid and
   // out_ready are both high; while out_valid is high and out_ready is low the
   // beat (addr/data/last) is held stable, and out_ready is ignored otherwise.

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              last_q, last_d;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      addr_d  = addr_q;
      data_d  = data_q;
      last_d  = last_q;
      case (state_q)
         S_IDLE: begin
            if (dump_req) state_d = S_READ;
         end
         S_READ: begin
            // The snapshot of this register is taken here and nowhere else.
            data_d  = rf_rd_data;
            addr_d  = idx_q;
            last_d  = (idx_q == LAST_IDX);
            state_d = S_SEND;
         end
         S_SEND: begin
            if (out_ready) begin
               if (last_q) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + ADDR_W'(1);
                  state_d = S_READ;
               end
            end
         end
         S_DONE: begin
            idx_d   = FIRST_IDX;
            state_d = S_IDLE;
         end
         default: begin
            idx_d   = FIRST_IDX;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= FIRST_IDX;
         addr_q  <= '0;
         data_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

   assign rf_rd_addr = idx_q;
   assign out_valid  = (state_q == S_SEND);
   assign dump_busy  = (state_q != S_IDLE);
   assign core_stall = dump_busy;
   assign dump_done  = (state_q == S_DONE);
   assign out_addr   = addr_q;
   assign out_data   = data_q;
   assign out_last   = last_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: one instance dumps from x0, one skips x0.
module tb_regfile_dump;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_a, ready_a, busy_a, stall_a, done_a, valid_a, last_a;
  logic [4:0]  rd_addr_a, addr_a;
  logic [31:0] rd_data_a, data_a;
  logic [1:0]  state_a;
  logic        req_b, ready_b, busy_b, stall_b, done_b, valid_b, last_b;
  logic [4:0]  rd_addr_b, addr_b;
  logic [31:0] rd_data_b, data_b;
  logic [1:0]  state_b;

  logic [31:0] rf [32];
  assign rd_data_a = rf[rd_addr_a];
  assign rd_data_b = rf[rd_addr_b];

  regfile_dump #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .SKIP_X0(0)) dut_a (
    .clk(clk), .rst(rst), .dump_req(req_a), .dump_busy(busy_a), .core_stall(stall_a),
    .dump_done(done_a), .rf_rd_addr(rd_addr_a), .rf_rd_data(rd_data_a),
    .out_valid(valid_a), .out_ready(ready_a), .out_addr(addr_a), .out_data(data_a),
    .out_last(last_a), .dbg_state(state_a));

  regfile_dump #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .SKIP_X0(1)) dut_b (
    .clk(clk), .rst(rst), .dump_req(req_b), .dump_busy(busy_b), .core_stall(stall_b),
    .dump_done(done_b), .rf_rd_addr(rd_addr_b), .rf_rd_data(rd_data_b),
    .out_valid(valid_b), .out_ready(ready_b), .out_addr(addr_b), .out_data(data_b),
    .out_last(last_b), .dbg_state(state_b));

  int checks = 0;
  int errors = 0;
  logic [37:0] exp_q[$];
  logic [37:0] exp_qb[$];
  int beats_a = 0, beats_b = 0, done_a_cnt = 0, done_b_cnt = 0, busy_cyc = 0;
  logic prev_last_hs = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [37:0] beat_of(input int i);
    logic [4:0] a;
    a = 5'(i);
    return {a, 32'hA500_0000 + 32'(i), (i == 31)};
  endfunction

  // Scoreboard for instance A, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_a && ready_a) begin
        beats_a++;
        check_eq("beat_a_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) check_eq("beat_a", {addr_a, data_a, last_a}, exp_q.pop_front());
      end
      if (done_a) begin
        done_a_cnt++;
        check_eq("done_after_last_a", prev_last_hs, 1);
        check_eq("done_no_valid_a", valid_a, 0);
      end
      prev_last_hs = valid_a && ready_a && last_a;
      if (busy_a) busy_cyc++;
      if (busy_a || stall_a) check_eq("stall_eq_busy_a", stall_a, busy_a);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (valid_b && ready_b) begin
        beats_b++;
        check_eq("beat_b_expected", 64'(exp_qb.size() > 0), 64'd1);
        if (exp_qb.size() > 0) check_eq("beat_b", {addr_b, data_b, last_b}, exp_qb.pop_front());
      end
      if (done_b) begin
        done_b_cnt++;
        check_eq("done_no_valid_b", valid_b, 0);
      end
    end
  end

  task automatic wait_done_a(input int target);
    int g;
    g = 0;
    while (done_a_cnt < target && g < 400) begin
      @(posedge clk); #1;
      g++;
    end
    check_eq("done_a_timeout", 64'(done_a_cnt >= target), 64'd1);
  endtask

  // Ready is granted one beat at a time; the beat at hold_addr is stalled or aborted.
  task automatic gated_dump(input int hold_addr, input int hold_cycles, input bit abort);
    int g;
    ready_a = 1'b0;
    req_a = 1'b1;
    @(posedge clk); #1;
    req_a = 1'b0;
    for (int b = 0; b < 32; b++) begin
      g = 0;
      while (!valid_a && g < 20) begin
        @(posedge clk); #1;
        g++;
      end
      check_eq("gated_valid", valid_a, 1);
      if (int'(addr_a) == hold_addr) begin
        if (abort) begin
          #2 rst = 1'b1;
          #1;
          check_eq("abort_valid", valid_a, 0);
          check_eq("abort_busy", busy_a, 0);
          check_eq("abort_done", done_a, 0);
          return;
        end
        for (int k = 0; k < hold_cycles; k++) begin
          check_eq("hold_valid", valid_a, 1);
          check_eq("hold_addr", addr_a, 64'(hold_addr));
          check_eq("hold_data", data_a, 64'(32'hA500_0000 + 32'(hold_addr)));
          check_eq("hold_stall", stall_a, 1);
          if (!stall_a) rf[hold_addr] = 32'hDEAD_BEEF;
          @(posedge clk); #1;
        end
      end
      ready_a = 1'b1;
      @(posedge clk); #1;
      ready_a = 1'b0;
      check_eq("post_hs_valid", valid_a, 0);
    end
  endtask

  initial begin
    int g;
    int d0;
    int b0;
    rst = 1'b1;
    req_a = 1'b0; ready_a = 1'b0; req_b = 1'b0; ready_b = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = 32'hA500_0000 + 32'(i);

    // Reset values and idle
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", valid_a, 0);
    check_eq("rst_addr", addr_a, 0);
    check_eq("rst_data", data_a, 0);
    check_eq("rst_last", last_a, 0);
    check_eq("rst_busy", busy_a, 0);
    check_eq("rst_stall", stall_a, 0);
    check_eq("rst_done", done_a, 0);
    check_eq("rst_rd_addr_a", rd_addr_a, 0);
    check_eq("rst_rd_addr_b", rd_addr_b, 1);
    rst = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    check_eq("idle_busy", busy_a, 0);
    check_eq("idle_valid", valid_a, 0);
    check_eq("idle_rd_addr", rd_addr_a, 0);
    check_eq("idle_state", state_a, 0);

    // Full dump with ready tied high
    for (int i = 0; i < 32; i++) exp_q.push_back(beat_of(i));
    ready_a = 1'b1;
    busy_cyc = 0;
    req_a = 1'b1;
    @(posedge clk); #1;
    req_a = 1'b0;
    check_eq("read_busy", busy_a, 1);
    check_eq("read_valid", valid_a, 0);
    @(posedge clk); #1;
    check_eq("first_valid", valid_a, 1);
    check_eq("first_addr", addr_a, 0);
    wait_done_a(1);
    check_eq("full_beats", beats_a, 32);
    check_eq("full_queue_empty", exp_q.size(), 0);
    check_eq("full_busy_cycles", busy_cyc, 65);
    @(posedge clk); #1;
    check_eq("full_idle_busy", busy_a, 0);

    // Backpressure on x5 while the core tries to write it
    for (int i = 0; i < 32; i++) exp_q.push_back(beat_of(i));
    gated_dump(5, 7, 1'b0);
    wait_done_a(2);
    check_eq("bp_beats", beats_a, 64);
    check_eq("bp_queue_empty", exp_q.size(), 0);
    check_eq("bp_x5_kept", rf[5], 32'hA500_0005);

    // SKIP_X0 instance
    for (int i = 1; i < 32; i++) exp_qb.push_back(beat_of(i));
    ready_b = 1'b1;
    req_b = 1'b1;
    @(posedge clk); #1;
    req_b = 1'b0;
    g = 0;
    while (done_b_cnt < 1 && g < 400) begin
      @(posedge clk); #1;
      g++;
    end
    check_eq("skip_done", done_b_cnt, 1);
    check_eq("skip_beats", beats_b, 31);
    check_eq("skip_queue_empty", exp_qb.size(), 0);

    // Re-pulsed dump_req mid-dump and on DONE is ignored
    d0 = done_a_cnt;
    b0 = beats_a;
    for (int i = 0; i < 32; i++) exp_q.push_back(beat_of(i));
    ready_a = 1'b1;
    req_a = 1'b1;
    @(posedge clk); #1;
    req_a = 1'b0;
    g = 0;
    while (beats_a < b0 + 10 && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    req_a = 1'b1;
    @(posedge clk); #1;
    req_a = 1'b0;
    g = 0;
    while (!done_a && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    check_eq("repulse_done_seen", done_a, 1);
    req_a = 1'b1;
    @(posedge clk); #1;
    req_a = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
    end
    check_eq("repulse_one_done", done_a_cnt, d0 + 1);
    check_eq("repulse_beats", beats_a, b0 + 32);
    check_eq("repulse_idle", busy_a, 0);

    // Reset during SEND on x12, then restart
    d0 = done_a_cnt;
    for (int i = 0; i < 12; i++) exp_q.push_back(beat_of(i));
    gated_dump(12, 0, 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check_eq("abort_no_done", done_a_cnt, d0);
    check_eq("abort_queue_empty", exp_q.size(), 0);
    check_eq("abort_rd_addr", rd_addr_a, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) exp_q.push_back(beat_of(i));
    ready_a = 1'b1;
    req_a = 1'b1;
    @(posedge clk); #1;
    req_a = 1'b0;
    @(posedge clk); #1;
    check_eq("restart_addr", addr_a, 0);
    wait_done_a(d0 + 1);
    check_eq("restart_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
